// File: rtl/sp_ram_arbiter.sv
// Two-port round-robin arbiter in front of one single-port block RAM.
// Zero-fills the RAM after reset or clr, then serves one access per cycle.
`timescale 1ns/1ps
module sp_ram_arbiter #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 18
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr,
    output logic              busy,

    input  logic              p0_valid,
    output logic              p0_ready,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,

    input  logic              p1_valid,
    output logic              p1_ready,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,

    output logic              rvalid,
    output logic              rport,
    output logic [DATA_W-1:0] rdata,

    output logic              ram_ce,
    output logic              ram_oce,
    output logic              ram_wre,
    output logic              ram_reset,
    output logic [ADDR_W-1:0] ram_ad,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] init_addr_reg, init_addr_next;
    logic              last_grant_reg, last_grant_next;
    logic              rvalid_reg, rvalid_next;
    logic              rport_reg, rport_next;

    logic [1:0]        valid_vec;
    logic [1:0]        we_vec;
    logic [ADDR_W-1:0] addr_arr [2];
    logic [DATA_W-1:0] wdata_arr [2];
    logic [1:0]        ready_vec;
    logic              grant_en;
    logic              grant_port;

    assign valid_vec    = {p1_valid, p0_valid};
    assign we_vec       = {p1_we, p0_we};
    assign addr_arr[0]  = p0_addr;
    assign addr_arr[1]  = p1_addr;
    assign wdata_arr[0] = p0_wdata;
    assign wdata_arr[1] = p1_wdata;

    // Grants only exist in SERVE, outside reset and outside a clr cycle.
    always_comb begin
        grant_en   = 1'b0;
        grant_port = 1'b0;
        if (reset_n && (state_reg == ST_SERVE) && !clr) begin
            case (valid_vec)
                2'b01: begin
                    grant_en   = 1'b1;
                    grant_port = 1'b0;
                end
                2'b10: begin
                    grant_en   = 1'b1;
                    grant_port = 1'b1;
                end
                2'b11: begin
                    grant_en   = 1'b1;
                    grant_port = ~last_grant_reg;
                end
                default: begin
                    grant_en   = 1'b0;
                    grant_port = 1'b0;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign ready_vec[gi] = grant_en && (grant_port == 1'(gi));
        end
    endgenerate

    assign p0_ready = ready_vec[0];
    assign p1_ready = ready_vec[1];

    always_comb begin
        state_next      = state_reg;
        init_addr_next  = init_addr_reg;
        last_grant_next = last_grant_reg;
        rvalid_next     = grant_en && !we_vec[grant_port];
        rport_next      = grant_en ? grant_port : rport_reg;
        ram_ce          = 1'b0;
        ram_wre         = 1'b0;
        ram_ad          = '0;
        ram_din         = '0;

        case (state_reg)
            ST_INIT: begin
                ram_ce         = 1'b1;
                ram_wre        = 1'b1;
                ram_ad         = init_addr_reg;
                init_addr_next = init_addr_reg + 1'b1;
                if (init_addr_reg == LAST_ADDR) begin
                    state_next = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (clr) begin
                    state_next     = ST_INIT;
                    init_addr_next = '0;
                end else if (grant_en) begin
                    ram_ce          = 1'b1;
                    ram_wre         = we_vec[grant_port];
                    ram_ad          = addr_arr[grant_port];
                    ram_din         = wdata_arr[grant_port];
                    last_grant_next = grant_port;
                end
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase

        // Keep the macro idle while reset is held.
        if (!reset_n) begin
            ram_ce  = 1'b0;
            ram_wre = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg      <= ST_INIT;
            init_addr_reg  <= '0;
            last_grant_reg <= 1'b1;
            rvalid_reg     <= 1'b0;
            rport_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            init_addr_reg  <= init_addr_next;
            last_grant_reg <= last_grant_next;
            rvalid_reg     <= rvalid_next;
            rport_reg      <= rport_next;
        end
    end

    assign busy      = !reset_n || (state_reg == ST_INIT);
    assign rvalid    = rvalid_reg;
    assign rport     = rport_reg;
    assign rdata     = ram_dout;
    assign ram_oce   = 1'b1;
    assign ram_reset = ~reset_n;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Scoreboard bench for sp_ram_arbiter with a behavioural 128x18 single-port RAM.
`timescale 1ns/1ps
module tb_sp_ram_arbiter;

    localparam int AW    = 7;
    localparam int DW    = 18;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n, clr, busy;
    logic          p0_valid, p0_ready, p0_we;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata;
    logic          p1_valid, p1_ready, p1_we;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic          rvalid, rport;
    logic [DW-1:0] rdata;
    logic          ram_ce, ram_oce, ram_wre, ram_reset;
    logic [AW-1:0] ram_ad;
    logic [DW-1:0] ram_din, ram_dout;

    always #5 clk = ~clk;

    sp_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset_n(reset_n), .clr(clr), .busy(busy),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .rvalid(rvalid), .rport(rport), .rdata(rdata),
        .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_wre(ram_wre),
        .ram_reset(ram_reset), .ram_ad(ram_ad), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    // RAM model seeded with a non-zero pattern so a missing zero-fill shows up.
    logic [DW-1:0] ram_mem [DEPTH];
    logic          ram_seeded = 1'b0;
    always @(posedge clk) begin
        if (!ram_seeded) begin
            for (int i = 0; i < DEPTH; i++) ram_mem[i] <= DW'(32'h15555 ^ i);
            ram_seeded <= 1'b1;
        end else if (ram_ce && ram_wre) begin
            ram_mem[ram_ad] <= ram_din;
        end
        if (ram_reset) ram_dout <= '0;
        else if (ram_ce && !ram_wre && ram_oce) ram_dout <= ram_mem[ram_ad];
    end

    typedef struct packed {
        logic          port;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          sb_q[$];
    logic [DW-1:0] shadow [DEPTH];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;

    logic          s_busy, s_p0_ready, s_p1_ready, s_acc0, s_acc1;
    logic          s_rvalid, s_rport, s_ram_ce, s_ram_wre, s_ram_reset, s_ram_oce;
    logic [AW-1:0] s_ram_ad;
    logic [DW-1:0] s_rdata, s_ram_din;

    // One clock cycle: sample at negedge, retire/queue reads, return at posedge+1.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        s_busy      = busy;
        s_p0_ready  = p0_ready;
        s_p1_ready  = p1_ready;
        s_acc0      = p0_valid && p0_ready;
        s_acc1      = p1_valid && p1_ready;
        s_rvalid    = rvalid;
        s_rport     = rport;
        s_rdata     = rdata;
        s_ram_ce    = ram_ce;
        s_ram_wre   = ram_wre;
        s_ram_reset = ram_reset;
        s_ram_oce   = ram_oce;
        s_ram_ad    = ram_ad;
        s_ram_din   = ram_din;
        if (rvalid) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_rvalid: got rport=%0d rdata=%h at cycle %0d, required no read return",
                         rport, rdata, cyc);
            end else begin
                e = sb_q.pop_front();
                if (rport !== e.port || rdata !== e.data || cyc != e.due) begin
                    errors++;
                    $display("FAIL sb_read_return: got rport=%0d rdata=%h cycle=%0d, required rport=%0d rdata=%h cycle=%0d",
                             rport, rdata, cyc, e.port, e.data, e.due);
                end
            end
        end else if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
            checks++;
            errors++;
            e = sb_q.pop_front();
            $display("FAIL sb_missing_rvalid: got rvalid=0 at cycle %0d, required rport=%0d rdata=%h",
                     cyc, e.port, e.data);
        end
        if (s_acc0) begin
            if (p0_we) shadow[p0_addr] = p0_wdata;
            else begin
                e.port = 1'b0; e.data = shadow[p0_addr]; e.due = cyc + 1;
                sb_q.push_back(e);
            end
        end
        if (s_acc1) begin
            if (p1_we) shadow[p1_addr] = p1_wdata;
            else begin
                e.port = 1'b1; e.data = shadow[p1_addr]; e.due = cyc + 1;
                sb_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int port, input logic v, input logic we,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (port == 0) begin
            p0_valid = v; p0_we = we; p0_addr = a; p0_wdata = d;
        end else begin
            p1_valid = v; p1_we = we; p1_addr = a; p1_wdata = d;
        end
    endtask

    task automatic zero_shadow();
        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
    endtask

    task automatic req(input int port, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
        logic accepted;
        accepted = 1'b0;
        set_port(port, 1'b1, we, a, d);
        for (int n = 0; n < 32 && !accepted; n++) begin
            tick();
            accepted = (port == 0) ? s_acc0 : s_acc1;
        end
        checks++;
        if (!accepted) begin
            errors++;
            $display("FAIL req_timeout: got no ready on port %0d addr %0d, required acceptance within 32 cycles",
                     port, a);
        end
        set_port(port, 1'b0, 1'b0, '0, '0);
    endtask

    // Counts busy cycles; bad counts INIT cycles that break the fill pattern or raise a ready.
    task automatic count_init(input int clr_at, output int n, output int bad);
        n = 0;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            clr = (n == clr_at);
            tick();
            clr = 1'b0;
            if (!s_busy) break;
            if (s_p0_ready || s_p1_ready || !s_ram_ce || !s_ram_wre ||
                s_ram_din !== '0 || s_ram_ad !== AW'(n)) bad++;
            n++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        set_port(0, 1'b1, 1'b0, 7'd0, '0);
        repeat (4) tick();
        checks++;
        if (s_p0_ready !== 1'b0 || s_p1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got p0_ready=%b p1_ready=%b, required 0 0", s_p0_ready, s_p1_ready);
        end
        checks++;
        if (s_ram_ce !== 1'b0 || s_busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_ce_busy: got ram_ce=%b busy=%b, required ram_ce=0 busy=1", s_ram_ce, s_busy);
        end
        checks++;
        if (s_rvalid !== 1'b0 || s_ram_reset !== 1'b1 || s_ram_oce !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs: got rvalid=%b ram_reset=%b ram_oce=%b, required 0 1 1",
                     s_rvalid, s_ram_reset, s_ram_oce);
        end
    endtask

    task automatic test_init_fill();
        int n, bad;
        logic [AW-1:0] addrs [3];
        addrs[0] = 7'd0; addrs[1] = 7'd77; addrs[2] = 7'd127;
        zero_shadow();
        reset_n = 1'b1;
        count_init(-1, n, bad);
        checks++;
        if (n != 128) begin
            errors++;
            $display("FAIL init_busy_cycles: got %0d busy cycles, required 128", n);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL init_sequence: got %0d bad INIT cycles, required 0", bad);
        end
        set_port(0, 1'b0, 1'b0, '0, '0);
        tick();
        for (int i = 1; i < 3; i++) begin
            req(0, 1'b0, addrs[i], '0);
            tick();
            checks++;
            if (s_rvalid !== 1'b1 || s_rdata !== '0) begin
                errors++;
                $display("FAIL init_readback: got rvalid=%b rdata=%h @%0d, required rvalid=1 rdata=0",
                         s_rvalid, s_rdata, addrs[i]);
            end
        end
    endtask

    task automatic test_write_read();
        req(0, 1'b1, 7'd5, 18'h2A5A5);
        set_port(1, 1'b1, 1'b0, 7'd5, '0);
        tick();
        checks++;
        if (s_p1_ready !== 1'b1) begin
            errors++;
            $display("FAIL wr_rd_ready: got p1_ready=%b, required 1", s_p1_ready);
        end
        set_port(1, 1'b0, 1'b0, '0, '0);
        tick();
        checks++;
        if (s_rvalid !== 1'b1 || s_rport !== 1'b1 || s_rdata !== 18'h2A5A5) begin
            errors++;
            $display("FAIL wr_rd_return: got rvalid=%b rport=%b rdata=%h, required 1 1 2a5a5",
                     s_rvalid, s_rport, s_rdata);
        end
    endtask

    task automatic test_round_robin();
        logic exp0;
        req(1, 1'b1, 7'd1, 18'h11111);
        req(1, 1'b1, 7'd2, 18'h22222);
        set_port(0, 1'b1, 1'b0, 7'd1, '0);
        set_port(1, 1'b1, 1'b0, 7'd2, '0);
        for (int i = 0; i < 6; i++) begin
            tick();
            exp0 = (i % 2 == 0);
            checks++;
            if (s_p0_ready !== exp0 || s_p1_ready !== !exp0) begin
                errors++;
                $display("FAIL rr_grant: cycle %0d got p0_ready=%b p1_ready=%b, required %b %b",
                         i, s_p0_ready, s_p1_ready, exp0, !exp0);
            end
        end
        set_port(0, 1'b0, 1'b0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0);
        tick();
        checks++;
        if (s_rvalid !== 1'b1 || s_rport !== 1'b1 || s_rdata !== 18'h22222) begin
            errors++;
            $display("FAIL rr_last_return: got rvalid=%b rport=%b rdata=%h, required 1 1 22222",
                     s_rvalid, s_rport, s_rdata);
        end
    endtask

    task automatic test_clr();
        int n, bad;
        set_port(0, 1'b1, 1'b0, 7'd5, '0);
        repeat (3) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (s_p0_ready !== 1'b0) begin
            errors++;
            $display("FAIL clr_ready: got p0_ready=%b in clr cycle, required 0", s_p0_ready);
        end
        checks++;
        if (s_rvalid !== 1'b1 || s_rdata !== 18'h2A5A5) begin
            errors++;
            $display("FAIL clr_pending_read: got rvalid=%b rdata=%h, required 1 2a5a5", s_rvalid, s_rdata);
        end
        zero_shadow();
        count_init(-1, n, bad);
        checks++;
        if (n != 128 || bad != 0) begin
            errors++;
            $display("FAIL clr_refill: got %0d busy cycles with %0d bad, required 128 with 0", n, bad);
        end
        set_port(0, 1'b0, 1'b0, '0, '0);
        tick();
        checks++;
        if (s_rvalid !== 1'b1 || s_rdata !== '0) begin
            errors++;
            $display("FAIL clr_old_data: got rvalid=%b rdata=%h @5, required 1 0", s_rvalid, s_rdata);
        end
    endtask

    task automatic test_reset_mid_init();
        int n, bad;
        logic found;
        found = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            found = s_busy && (s_ram_ad == 7'd59);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL mid_init_reach: got no INIT address 59, required it within 200 cycles");
        end
        reset_n = 1'b0;
        set_port(0, 1'b1, 1'b0, 7'd0, '0);
        set_port(1, 1'b1, 1'b0, 7'd0, '0);
        tick();
        checks++;
        if (s_ram_ce !== 1'b0 || s_busy !== 1'b1 || s_p0_ready || s_p1_ready) begin
            errors++;
            $display("FAIL mid_init_reset: got ram_ce=%b busy=%b readies=%b%b, required 0 1 00",
                     s_ram_ce, s_busy, s_p0_ready, s_p1_ready);
        end
        reset_n = 1'b1;
        zero_shadow();
        count_init(-1, n, bad);
        checks++;
        if (n != 128 || bad != 0) begin
            errors++;
            $display("FAIL mid_init_rerun: got %0d busy cycles with %0d bad, required 128 with 0", n, bad);
        end
        set_port(0, 1'b0, 1'b0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0);
        tick();
    endtask

    task automatic test_clr_in_init();
        int n, bad;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        zero_shadow();
        count_init(20, n, bad);
        checks++;
        if (n != 128 || bad != 0) begin
            errors++;
            $display("FAIL clr_in_init: got %0d busy cycles with %0d bad, required 128 with 0", n, bad);
        end
        tick();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d outstanding reads, required 0", sb_q.size());
        end
    endtask

    initial begin
        reset_n = 1'b0;
        clr     = 1'b0;
        set_port(0, 1'b0, 1'b0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0);
        zero_shadow();
        test_reset();
        test_init_fill();
        test_write_read();
        test_round_robin();
        test_clr();
        test_reset_mid_init();
        test_clr_in_init();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
